// File: rtl/sdboot_loader.sv
// -----------------------------------------------------------------------------
// sdboot_loader
//
// Boot-time sector sequencer and RAM writer. It sits directly after the SD-SPI
// sector reader and walks SECTOR_COUNT sectors starting at SECTOR_BASE using
// the reader's rstart/rsector handshake. The reader's byte stream is packed
// into little-endian 32-bit words, buffered in a small FIFO, and written to RAM
// at RAM_BASE upward over a req/ack bus. done is raised once the whole image
// is in memory.
//
// Optional feature (compile-time macro SDBOOT_CHECKSUM_EN):
//   defined   -> checksum is the 32-bit modular sum of every word accepted by
//                RAM (mem_ack), cleared on start.
//   undefined -> checksum is tied to 0 and no adder is built.
//
// Ports:
//   clk, rstn          clock, synchronous active-low reset
//   start              one-cycle pulse; starts a copy from IDLE/DONE/ERR
//   rstart, rsector    sector read request and sector number to the reader
//   rbusy              reader busy (status only, not used)
//   rdone              reader pulse: current sector complete
//   outen/outaddr/     byte strobe, byte index 0..511 in sector, byte data
//   outbyte
//   mem_req/mem_addr/  RAM write request, word-aligned byte address, data
//   mem_wdata
//   mem_ack            RAM accepted the current request
//   busy, done         copy in progress / copy finished without error
//   err_overflow       sticky: a packed word was lost because the FIFO was full
//   err_seq            sticky: outaddr differed from the expected byte index
//   sectors_done       sectors completed in this run
//   checksum           running word checksum (see macro above)
// -----------------------------------------------------------------------------
module sdboot_loader #(
  parameter logic [31:0] SECTOR_BASE  = 32'h0000_0800,
  parameter logic [31:0] SECTOR_COUNT = 32'd16384,
  parameter logic [31:0] RAM_BASE     = 32'h8000_0000,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  output logic        rstart,
  output logic [31:0] rsector,
  input  logic        rbusy,
  input  logic        rdone,
  input  logic        outen,
  input  logic [8:0]  outaddr,
  input  logic [7:0]  outbyte,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  output logic        busy,
  output logic        done,
  output logic        err_overflow,
  output logic        err_seq,
  output logic [31:0] sectors_done,
  output logic [31:0] checksum
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_GAP,
    S_DRAIN,
    S_DONE,
    S_ERR
  } state_t;

  state_t state;

  // Word FIFO
  logic [31:0]   fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;

  // Byte packing
  logic [8:0]  exp_idx;   // next expected byte index within the sector
  logic [23:0] lanes;     // bytes 0..2 of the word being assembled
  logic [29:0] word_idx;  // words written this run; 30 bits give byte-address wrap

  // The reader's busy flag is informational only.
  logic unused_rbusy;
  assign unused_rbusy = rbusy;

  // ---------------------------------------------------------------------------
  // Per-cycle events
  // ---------------------------------------------------------------------------
  logic        start_now;
  logic        byte_en;
  logic        seq_bad;
  logic        push_req;
  logic        fifo_full;
  logic        pop_now;
  logic        ovf_now;
  logic        err_now;
  logic        wr_en;
  logic [31:0] word_in;

  assign start_now = start && ((state == S_IDLE) || (state == S_DONE) || (state == S_ERR));
  // Bytes only count while a sector request is open.
  assign byte_en   = outen && (state == S_REQ);
  assign seq_bad   = byte_en && (outaddr != exp_idx);
  assign push_req  = byte_en && (outaddr[1:0] == 2'd3);
  assign fifo_full = (count == CW'(FIFO_DEPTH));
  assign mem_req   = (count != '0);
  assign pop_now   = mem_req && mem_ack;
  // A pop in the same cycle frees the slot, so a full FIFO only overflows
  // when nothing leaves.
  assign ovf_now   = push_req && fifo_full && !pop_now;
  assign err_now   = seq_bad || ovf_now;
  assign wr_en     = push_req && !err_now;
  // The current byte goes straight into lane 3 so the word is pushed this cycle.
  assign word_in   = {outbyte, lanes};

  // Address and data are zero whenever no request is being presented.
  assign mem_addr  = mem_req ? (RAM_BASE + {word_idx, 2'b00}) : '0;
  assign mem_wdata = mem_req ? fifo_mem[rd_ptr] : '0;

  // ---------------------------------------------------------------------------
  // Sequencer FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state        <= S_IDLE;
      rstart       <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      rsector      <= SECTOR_BASE;
      sectors_done <= '0;
      err_seq      <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      if (seq_bad) err_seq      <= 1'b1;
      if (ovf_now) err_overflow <= 1'b1;

      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            // NOTE: when several non-blocking assignments hit the same register
            // in one cycle the last one in program order wins, so these clears
            // override the sticky-set lines above.
            state        <= S_REQ;
            rstart       <= 1'b1;
            busy         <= 1'b1;
            done         <= 1'b0;
            rsector      <= SECTOR_BASE;
            sectors_done <= '0;
            err_seq      <= 1'b0;
            err_overflow <= 1'b0;
          end
        end

        S_REQ: begin
          if (err_now) begin
            state  <= S_ERR;
            rstart <= 1'b0;
            busy   <= 1'b0;
          end else if (rdone) begin
            sectors_done <= sectors_done + 32'd1;
            state        <= S_GAP;
            rstart       <= 1'b0;
          end
        end

        // One low cycle on rstart between sector requests.
        S_GAP: begin
          if (sectors_done == SECTOR_COUNT) begin
            state <= S_DRAIN;
          end else begin
            rsector <= rsector + 32'd1;
            state   <= S_REQ;
            rstart  <= 1'b1;
          end
        end

        S_DRAIN: begin
          if (!mem_req) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end

        default: begin
          state  <= S_IDLE;
          rstart <= 1'b0;
          busy   <= 1'b0;
          done   <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Byte packing, FIFO pointers and RAM word index
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      exp_idx  <= '0;
      lanes    <= '0;
      word_idx <= '0;
    end else if (start_now) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      exp_idx  <= '0;
      word_idx <= '0;
    end else if (err_now) begin
      // Entering ERR discards the FIFO; a word RAM accepted this cycle still counts.
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      if (pop_now) word_idx <= word_idx + 30'd1;
    end else begin
      if (byte_en) begin
        exp_idx <= exp_idx + 9'd1;  // wraps 511 -> 0 at the sector boundary
        case (outaddr[1:0])
          2'd0:    lanes[7:0]   <= outbyte;
          2'd1:    lanes[15:8]  <= outbyte;
          2'd2:    lanes[23:16] <= outbyte;
          default: ;
        endcase
      end
      if (push_req) wr_ptr <= wr_ptr + 1'b1;
      if (pop_now) begin
        rd_ptr   <= rd_ptr + 1'b1;
        word_idx <= word_idx + 30'd1;
      end
      case ({push_req, pop_now})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // NOTE: the FIFO storage has no reset; only the pointers and count do, and
  // mem_wdata is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (wr_en) fifo_mem[wr_ptr] <= word_in;
  end

`ifdef SDBOOT_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (!rstn) begin
      checksum <= '0;
    end else if (start_now) begin
      checksum <= '0;
    end else if (pop_now) begin
      checksum <= checksum + mem_wdata;
    end
  end
`else
  assign checksum = '0;
`endif

endmodule
